// File: rtl/fp_mult_array_pipe.sv
// Purpose : NUM_LANES parallel floating-point multipliers (FTZ, round-toward-zero) with a lane enable mask.
// Latency : 3 register stages; a vector transferred on one clock edge appears on out_vld after the 3rd edge.
// Backpr. : all stages advance together only when the output register is empty or being consumed.
// Optional: define FP_MULT_ARRAY_FLAGS_EN to add sticky exception flags (flags_o / flags_clr).
module fp_mult_array_pipe #(
    parameter int NUM_LANES = 32,
    parameter int EXP_W     = 8,
    parameter int MAN_W     = 23,
    localparam int DATA_WIDTH = 1 + EXP_W + MAN_W
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_vld,
    output logic                            in_rdy,
    input  logic [NUM_LANES-1:0]            lane_en,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] weight_vec,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] data_vec,
    output logic [NUM_LANES*DATA_WIDTH-1:0] prod_vec,
    output logic                            out_vld,
    input  logic                            out_rdy
`ifdef FP_MULT_ARRAY_FLAGS_EN
    ,
    output logic [3:0]                      flags_o,
    input  logic                            flags_clr
`endif
);

    localparam int PROD_W = 2 * MAN_W + 2;
    // Signed working width for the exponent: sum of two exponents minus bias, plus carry.
    localparam int EXP_SW = EXP_W + 2;
    localparam logic [EXP_SW-1:0] BIAS    = EXP_SW'((1 << (EXP_W - 1)) - 1);
    localparam logic [EXP_SW-1:0] EXP_MAX = EXP_SW'((1 << EXP_W) - 1);
    localparam logic [DATA_WIDTH-1:0] QNAN =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic pipe_adv;
    logic s1_vld;
    logic s2_vld;

    // Stage 1 state: classification, sign, raw exponent, top bits of the mantissa product.
    logic [NUM_LANES-1:0]              s1_sign_d, s1_sign_q;
    logic [NUM_LANES-1:0]              s1_nan_d,  s1_nan_q;
    logic [NUM_LANES-1:0]              s1_inf_d,  s1_inf_q;
    logic [NUM_LANES-1:0]              s1_zero_d, s1_zero_q;
    logic [NUM_LANES-1:0]              s1_en_q;
    logic [NUM_LANES-1:0][EXP_SW-1:0]  s1_exp_d,  s1_exp_q;
    logic [NUM_LANES-1:0][MAN_W+1:0]   s1_man_d,  s1_man_q;

    // Stage 2 / 3 state: packed lane results.
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0] s2_res_d, s2_res_q;
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0] s3_res_q;

`ifdef FP_MULT_ARRAY_FLAGS_EN
    logic [NUM_LANES-1:0]      s1_ftz_d, s1_ftz_q;
    logic [NUM_LANES-1:0][3:0] s2_flag_d;
    logic [3:0]                s2_flag_or;
    logic [3:0]                s2_flag_q;
    logic [3:0]                s3_flag_q;
    logic [3:0]                flags_q;
`endif

    // The whole pipe moves as one; a full, unconsumed output register freezes every stage.
    assign pipe_adv = ~out_vld | out_rdy;
    assign in_rdy   = pipe_adv;
    assign prod_vec = s3_res_q;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [DATA_WIDTH-1:0] op_a, op_b;
        logic [EXP_W-1:0]      ea, eb;
        logic [MAN_W-1:0]      ma, mb;
        logic                  a_zero, a_inf, a_nan;
        logic                  b_zero, b_inf, b_nan;
        logic [PROD_W-1:0]     full_prod;
        logic                  unused_prod_low;

        logic                  carry;
        logic [EXP_SW-1:0]     nexp;
        logic [MAN_W-1:0]      nman;
        logic                  ovf, unf;
        logic                  res_nan, res_inf, res_unf;
        logic [DATA_WIDTH-1:0] res;

        assign op_a = weight_vec[i*DATA_WIDTH +: DATA_WIDTH];
        assign op_b = data_vec[i*DATA_WIDTH +: DATA_WIDTH];

        // Unpack and classify operands; exponent-zero operands are flushed to signed zero.
        always_comb begin
            ea        = op_a[MAN_W +: EXP_W];
            eb        = op_b[MAN_W +: EXP_W];
            ma        = op_a[MAN_W-1:0];
            mb        = op_b[MAN_W-1:0];
            a_zero    = (ea == '0);
            b_zero    = (eb == '0);
            a_inf     = (ea == {EXP_W{1'b1}}) && (ma == '0);
            b_inf     = (eb == {EXP_W{1'b1}}) && (mb == '0);
            a_nan     = (ea == {EXP_W{1'b1}}) && (ma != '0);
            b_nan     = (eb == {EXP_W{1'b1}}) && (mb != '0);
            full_prod = PROD_W'({1'b1, ma}) * PROD_W'({1'b1, mb});
        end

        assign s1_sign_d[i] = op_a[DATA_WIDTH-1] ^ op_b[DATA_WIDTH-1];
        assign s1_nan_d[i]  = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
        assign s1_inf_d[i]  = a_inf | b_inf;
        assign s1_zero_d[i] = a_zero | b_zero;
        assign s1_exp_d[i]  = EXP_SW'(ea) + EXP_SW'(eb) - BIAS;
        // Only the bits that survive truncation are carried forward.
        assign s1_man_d[i]  = full_prod[PROD_W-1 -: MAN_W+2];
        assign unused_prod_low = ^full_prod[MAN_W-1:0];

        // Normalise by at most one position and pick the special-case result.
        always_comb begin
            carry   = s1_man_q[i][MAN_W+1];
            nman    = carry ? s1_man_q[i][MAN_W:1] : s1_man_q[i][MAN_W-1:0];
            nexp    = s1_exp_q[i] + {{(EXP_SW-1){1'b0}}, carry};
            ovf     = $signed(nexp) >= $signed(EXP_MAX);
            unf     = $signed(nexp) <= $signed({EXP_SW{1'b0}});
            res_nan = s1_nan_q[i];
            res_inf = ~res_nan & (s1_inf_q[i] | (~s1_zero_q[i] & ovf));
            res_unf = ~res_nan & ~s1_inf_q[i] & ~s1_zero_q[i] & unf;
            res     = {s1_sign_q[i], nexp[EXP_W-1:0], nman};
            if (!s1_en_q[i]) begin
                res = '0;
            end else if (res_nan) begin
                res = QNAN;
            end else if (res_inf) begin
                res = {s1_sign_q[i], {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end else if (s1_zero_q[i] || res_unf) begin
                res = {s1_sign_q[i], {(DATA_WIDTH-1){1'b0}}};
            end
        end

        assign s2_res_d[i] = res;

`ifdef FP_MULT_ARRAY_FLAGS_EN
        // Denormal input seen on either operand (it was flushed to zero).
        assign s1_ftz_d[i]  = (a_zero && (ma != '0)) || (b_zero && (mb != '0));
        // Lane flags {nan, inf_ovf, unf, ftz_in}; disabled lanes never contribute.
        assign s2_flag_d[i] = s1_en_q[i] ? {res_nan, res_inf, res_unf, s1_ftz_q[i]} : 4'b0000;
`endif
    end

    // Valid bits shift with the pipe; bubbles are kept, not collapsed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s2_vld  <= 1'b0;
            out_vld <= 1'b0;
        end else if (pipe_adv) begin
            s1_vld  <= in_vld;
            s2_vld  <= s1_vld;
            out_vld <= s2_vld;
        end
    end

    // Stage 1 register: operand decode and mantissa product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_sign_q <= '0;
            s1_nan_q  <= '0;
            s1_inf_q  <= '0;
            s1_zero_q <= '0;
            s1_en_q   <= '0;
            s1_exp_q  <= '0;
            s1_man_q  <= '0;
        end else if (pipe_adv) begin
            s1_sign_q <= s1_sign_d;
            s1_nan_q  <= s1_nan_d;
            s1_inf_q  <= s1_inf_d;
            s1_zero_q <= s1_zero_d;
            s1_en_q   <= lane_en;
            s1_exp_q  <= s1_exp_d;
            s1_man_q  <= s1_man_d;
        end
    end

    // Stage 2 register: packed lane results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_res_q <= '0;
        end else if (pipe_adv) begin
            s2_res_q <= s2_res_d;
        end
    end

    // Stage 3 register: the output vector, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_res_q <= '0;
        end else if (pipe_adv) begin
            s3_res_q <= s2_res_q;
        end
    end

`ifdef FP_MULT_ARRAY_FLAGS_EN
    // OR the per-lane flags into one vector-level flag set.
    always_comb begin
        s2_flag_or = 4'b0000;
        for (int l = 0; l < NUM_LANES; l++) begin
            s2_flag_or = s2_flag_or | s2_flag_d[l];
        end
    end

    // Flag side pipe tracks the data stages one-for-one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_ftz_q  <= '0;
            s2_flag_q <= '0;
            s3_flag_q <= '0;
        end else if (pipe_adv) begin
            s1_ftz_q  <= s1_ftz_d;
            s2_flag_q <= s2_flag_or;
            s3_flag_q <= s2_flag_q;
        end
    end

    // Sticky flags: accumulate only consumed vectors; a coincident set beats the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 4'b0000;
        end else if (out_vld && out_rdy) begin
            flags_q <= (flags_clr ? 4'b0000 : flags_q) | s3_flag_q;
        end else if (flags_clr) begin
            flags_q <= 4'b0000;
        end
    end

    assign flags_o = flags_q;
`endif

endmodule
